// File: rtl/mem_mmio_unit.sv
// rtl/mem_mmio_unit.sv - RV32 load/store unit: BRAM port plus memory-mapped GPO register bank
// Optional macro MISALIGN_TRAP_EN: misaligned halfword/word accesses respond with rsp_err instead of being aligned.
module mem_mmio_unit #(
  parameter int              XLEN       = 32,
  parameter int              MEM_ADDR_W = 12,
  parameter int              MEM_RD_LAT = 1,
  parameter logic [XLEN-1:0] MMIO_BASE  = 32'h0000_0034,
  parameter int              NUM_GPO    = 4,
  parameter logic [XLEN-1:0] GPO_RESET  = 32'h0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [2:0]              req_funct3,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_wdata,
  output logic                    rsp_valid,
  output logic [XLEN-1:0]         rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic [XLEN/8-1:0]       mem_we,
  output logic [MEM_ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic [XLEN-1:0]         mem_rdata,
  output logic [NUM_GPO*XLEN-1:0] gpo
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam int              AW       = MEM_ADDR_W + 2;
  localparam logic [XLEN-1:0] MMIO_END = MMIO_BASE + XLEN'(4 * NUM_GPO);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              mmio_q, mmio_d;
  logic [2:0]        gidx_q, gidx_d;
  logic              mis_q, mis_d;
  logic [3:0]        strb_q, strb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              mem_en_q, mem_en_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   gpo_q [NUM_GPO];
  logic [XLEN-1:0]   gpo_d [NUM_GPO];

  logic [1:0]        req_size;
  logic              req_mis;
  logic [XLEN-1:0]   req_addr_al;
  logic [XLEN-1:0]   req_off;
  logic              req_mmio;
  logic [3:0]        req_strb;
  logic [XLEN-1:0]   req_wrep;
  logic [XLEN-1:0]   gpo_sel;

  // Access size: 0 = byte, 1 = halfword, 2 = word. Stores treat every unknown funct3 as a word.
  always_comb begin
    if (req_we) begin
      req_size = (req_funct3 == 3'b000) ? 2'd0 : (req_funct3 == 3'b001) ? 2'd1 : 2'd2;
    end else begin
      req_size = (req_funct3[1:0] == 2'b00) ? 2'd0 : (req_funct3[1:0] == 2'b01) ? 2'd1 : 2'd2;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign req_mis     = ((req_size == 2'd1) && req_addr[0]) ||
                       ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign req_addr_al = req_addr;
`else
  assign req_mis = 1'b0;
  always_comb begin
    req_addr_al = req_addr;
    if (req_size == 2'd1) begin
      req_addr_al[0] = 1'b0;
    end else if (req_size == 2'd2) begin
      req_addr_al[1:0] = 2'b00;
    end
  end
`endif

  assign req_mmio = (req_addr_al >= MMIO_BASE) && (req_addr_al < MMIO_END);
  assign req_off  = req_addr_al - MMIO_BASE;

  // Store data is replicated across lanes so the strobes alone pick the bytes written.
  always_comb begin
    case (req_size)
      2'd0: begin
        req_strb = 4'b0001 << req_addr_al[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_strb = 4'b0011 << {req_addr_al[1], 1'b0};
        req_wrep = {2{req_wdata[15:0]}};
      end
      default: begin
        req_strb = 4'b1111;
        req_wrep = req_wdata;
      end
    endcase
  end

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [2:0]      f3,
                                                   input logic [1:0]      a);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = a[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    gpo_sel = '0;
    for (int i = 0; i < NUM_GPO; i++) begin
      if (gidx_q == 3'(i)) gpo_sel = gpo_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    mmio_d      = mmio_q;
    gidx_d      = gidx_q;
    mis_d       = mis_q;
    strb_d      = strb_q;
    wdata_d     = wdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    gpo_d       = gpo_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d  = S_ISSUE;
          we_d     = req_we;
          f3_d     = req_funct3;
          addr_d   = req_addr_al[AW-1:0];
          mmio_d   = req_mmio;
          gidx_d   = 3'(req_off >> 2);
          mis_d    = req_mis;
          strb_d   = req_strb;
          wdata_d  = req_wrep;
          mem_en_d = !req_mmio && !req_mis;
          mem_we_d = (!req_mmio && !req_mis && req_we) ? req_strb : 4'b0000;
        end
      end
      S_ISSUE: begin
        mem_en_d = 1'b0;
        mem_we_d = 4'b0000;
        if (mis_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (mmio_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : load_extract(gpo_sel, f3_q, addr_q[1:0]);
          if (we_q) begin
            for (int i = 0; i < NUM_GPO; i++) begin
              for (int b = 0; b < 4; b++) begin
                if ((gidx_q == 3'(i)) && strb_q[b]) gpo_d[i][8*b +: 8] = wdata_q[8*b +: 8];
              end
            end
          end
        end else if (we_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = S_WAIT;
          cnt_d   = 2'(MEM_RD_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_extract(mem_rdata, f3_q, addr_q[1:0]);
          rsp_err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      addr_q      <= '0;
      mmio_q      <= 1'b0;
      gidx_q      <= 3'd0;
      mis_q       <= 1'b0;
      strb_q      <= 4'b0000;
      wdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      cnt_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < NUM_GPO; i++) gpo_q[i] <= GPO_RESET;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      mmio_q      <= mmio_d;
      gidx_q      <= gidx_d;
      mis_q       <= mis_d;
      strb_q      <= strb_d;
      wdata_q     <= wdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      gpo_q       <= gpo_d;
    end
  end

  assign req_ready = (state_q == S_IDLE) && resetn;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q[AW-1:2];
  assign mem_wdata = wdata_q;

  for (genvar g = 0; g < NUM_GPO; g++) begin : g_gpo
    assign gpo[g*XLEN +: XLEN] = gpo_q[g];
  end

endmodule

// File: tb/tb_mem_mmio_unit.sv
// tb/tb_mem_mmio_unit.sv - self-checking bench for mem_mmio_unit (table vectors, corner sequences, random vs byte-level model)
module tb_mem_mmio_unit;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h34;
  localparam int          NG   = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b0;
  logic [31:0]   req_addr = 32'h0, req_wdata = 32'h0;
  logic          rsp_valid, rsp_err, mem_en;
  logic [31:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [3:0]    mem_we;
  logic [11:0]   mem_addr;
  logic [NG*32-1:0] gpo;

  always #5 clk = ~clk;

  mem_mmio_unit #(.XLEN(32), .MEM_ADDR_W(12), .MEM_RD_LAT(LAT), .MMIO_BASE(BASE),
                  .NUM_GPO(NG), .GPO_RESET(32'h0)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gpo(gpo));

  // BRAM stub with LAT-cycle registered read
  logic [31:0] bram [4096] = '{default: 32'h0};
  logic [31:0] pipe [LAT]  = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      pipe[0] <= bram[mem_addr];
    end
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT-1];

  // Reference model: byte-addressed memory image (aliased over 2^14 bytes) plus GPO words
  logic [7:0]  ref_bytes [16384] = '{default: 8'h0};
  logic [31:0] ref_gpo [NG]      = '{default: 32'h0};

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int acc_bytes(input logic we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata,
                            output logic err, output int lat, output logic uses_mem);
    int n, idx, lane, ba;
    logic [31:0] a;
    logic [63:0] v;
    logic mmio;
    n = acc_bytes(we, f3);
    rdata = 32'h0; err = 1'b0; lat = 2; uses_mem = 1'b0; v = 64'h0;
    a = addr - (addr % 32'(n));
    if (TRAP && (a != addr)) begin
      err = 1'b1;
    end else begin
      mmio = (a >= BASE) && (a < BASE + 32'(4*NG));
      uses_mem = !mmio;
      idx = int'((a - BASE) / 4);
      if (!we && !mmio) lat = 2 + LAT;
      for (int k = 0; k < n; k++) begin
        lane = int'((a + 32'(k)) % 4);
        ba   = int'((a + 32'(k)) % 16384);
        if (we) begin
          if (mmio) ref_gpo[idx][8*lane +: 8] = wdata[8*k +: 8];
          else      ref_bytes[ba]             = wdata[8*k +: 8];
        end else begin
          if (mmio) v[8*k +: 8] = ref_gpo[idx][8*lane +: 8];
          else      v[8*k +: 8] = ref_bytes[ba];
        end
      end
      if (!we) begin
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | (~64'h0 << (8*n));
        rdata = v[31:0];
      end
    end
  endtask

  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                         output int lat, output logic saw_en, output logic [3:0] obs_we,
                         output logic [11:0] obs_maddr);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    lat = 0; saw_en = 1'b0; obs_we = 4'h0; obs_maddr = 12'h0; rdata = 32'h0; err = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (mem_en) begin
        saw_en = 1'b1; obs_we = mem_we; obs_maddr = mem_addr;
      end
      if (rsp_valid) begin
        rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [3:0]  exp_we;
    logic        exp_men;
    logic [11:0] exp_maddr;
  } vec_t;

  vec_t        vt [16];
  logic [31:0] o_rdata, m_rdata;
  logic        o_err, o_en, m_err, m_mem;
  int          o_lat, m_lat;
  logic [3:0]  o_we;
  logic [11:0] o_maddr;
  int          n_acc, n_rsp, last_acc, bad_gap, bad_data, cnt;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r, wd_r;

  initial begin
    vt[0]  = '{1'b1, 3'b010, 32'h100,  32'hDEADBEEF, 32'h0,        2,     4'b1111, 1'b1, 12'h040};
    vt[1]  = '{1'b0, 3'b010, 32'h100,  32'h0,        32'hDEADBEEF, 2+LAT, 4'b0000, 1'b1, 12'h040};
    vt[2]  = '{1'b1, 3'b000, 32'h101,  32'h80,       32'h0,        2,     4'b0010, 1'b1, 12'h040};
    vt[3]  = '{1'b0, 3'b000, 32'h101,  32'h0,        32'hFFFFFF80, 2+LAT, 4'b0000, 1'b1, 12'h040};
    vt[4]  = '{1'b0, 3'b100, 32'h101,  32'h0,        32'h00000080, 2+LAT, 4'b0000, 1'b1, 12'h040};
    vt[5]  = '{1'b1, 3'b010, 32'h34,   32'h5A,       32'h0,        2,     4'b0000, 1'b0, 12'h000};
    vt[6]  = '{1'b1, 3'b001, 32'h3A,   32'h1234,     32'h0,        2,     4'b0000, 1'b0, 12'h000};
    vt[7]  = '{1'b0, 3'b010, 32'h38,   32'h0,        32'h12340000, 2,     4'b0000, 1'b0, 12'h000};
    vt[8]  = '{1'b0, 3'b010, 32'h34,   32'h0,        32'h0000005A, 2,     4'b0000, 1'b0, 12'h000};
    vt[9]  = '{1'b1, 3'b010, 32'h44,   32'hCAFEF00D, 32'h0,        2,     4'b1111, 1'b1, 12'h011};
    vt[10] = '{1'b0, 3'b010, 32'h4044, 32'h0,        32'hCAFEF00D, 2+LAT, 4'b0000, 1'b1, 12'h011};
    vt[11] = '{1'b0, 3'b001, 32'h46,   32'h0,        32'hFFFFCAFE, 2+LAT, 4'b0000, 1'b1, 12'h011};
    vt[12] = '{1'b0, 3'b101, 32'h46,   32'h0,        32'h0000CAFE, 2+LAT, 4'b0000, 1'b1, 12'h011};
    vt[13] = '{1'b1, 3'b000, 32'h35,   32'h77,       32'h0,        2,     4'b0000, 1'b0, 12'h000};
    vt[14] = '{1'b0, 3'b010, 32'h34,   32'h0,        32'h0000775A, 2,     4'b0000, 1'b0, 12'h000};
    vt[15] = '{1'b0, 3'b000, 32'h30,   32'h0,        32'h0,        2+LAT, 4'b0000, 1'b1, 12'h00C};

    // Reset held for two cycles
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_gpo0", gpo[31:0], 32'h0);
    chk("rst_gpo3", gpo[127:96], 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 16; i++) begin
      run_txn(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, o_rdata, o_err, o_lat, o_en, o_we, o_maddr);
      ref_access(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, m_rdata, m_err, m_lat, m_mem);
      chk($sformatf("tbl%0d_rdata", i), o_rdata, vt[i].exp_rdata);
      chk($sformatf("tbl%0d_lat", i), 32'(o_lat), 32'(vt[i].exp_lat));
      chk($sformatf("tbl%0d_err", i), 32'(o_err), 32'h0);
      chk($sformatf("tbl%0d_mem_en", i), 32'(o_en), 32'(vt[i].exp_men));
      if (vt[i].exp_men) begin
        chk($sformatf("tbl%0d_mem_we", i), 32'(o_we), 32'(vt[i].exp_we));
        chk($sformatf("tbl%0d_mem_addr", i), 32'(o_maddr), 32'(vt[i].exp_maddr));
      end
    end
    chk("gpo0", gpo[31:0], 32'h0000775A);
    chk("gpo1", gpo[63:32], 32'h12340000);
    chk("gpo2", gpo[95:64], 32'h0);
    chk("gpo3", gpo[127:96], 32'h0);

    // req_valid held high: accepts only from IDLE, spaced by a full transaction
    ref_access(1'b0, 3'b010, 32'h100, 32'h0, m_rdata, m_err, m_lat, m_mem);
    n_acc = 0; n_rsp = 0; last_acc = 0; bad_gap = 0; bad_data = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    for (int c = 0; c < 50; c++) begin
      if (c == 40) req_valid = 1'b0;
      if (req_valid && req_ready) begin
        if (n_acc > 0 && (c - last_acc) != 3 + LAT) bad_gap++;
        last_acc = c;
        n_acc++;
      end
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_rdata !== m_rdata) bad_data++;
      end
      @(negedge clk);
    end
    chk("hold_accepts", 32'(n_acc), 32'(40 / (3 + LAT)));
    chk("hold_rsp_per_accept", 32'(n_rsp), 32'(n_acc));
    chk("hold_gap", 32'(bad_gap), 32'h0);
    chk("hold_data", 32'(bad_data), 32'h0);

    // Reset during WAIT of a load abandons it
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("t6_issue_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("t6_wait_ready", 32'(req_ready), 32'h0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("t6_ready_after_rst", 32'(req_ready), 32'h1);
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid) cnt++;
      @(negedge clk);
    end
    chk("t6_no_rsp", 32'(cnt), 32'h0);
    chk("t6_gpo0_reset", gpo[31:0], 32'h0);
    chk("t6_gpo1_reset", gpo[63:32], 32'h0);
    for (int i = 0; i < NG; i++) ref_gpo[i] = 32'h0;

    // Misaligned word load: trap or silently aligned depending on build
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, o_rdata, o_err, o_lat, o_en, o_we, o_maddr);
    ref_access(1'b0, 3'b010, 32'h102, 32'h0, m_rdata, m_err, m_lat, m_mem);
    chk("mis_rdata", o_rdata, TRAP ? 32'h0 : 32'hDEAD80EF);
    chk("mis_err", 32'(o_err), 32'(TRAP));
    chk("mis_mem_en", 32'(o_en), 32'(!TRAP));
    chk("mis_lat", 32'(o_lat), TRAP ? 32'd2 : 32'(2 + LAT));

    // Random traffic against the byte-level model
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 2) == 0) addr_r = BASE + 32'($urandom_range(0, 4*NG - 1));
      else addr_r = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 127));
      we_r = 1'($urandom_range(0, 1));
      f3_r = 3'($urandom_range(0, 7));
      wd_r = $urandom;
      run_txn(we_r, f3_r, addr_r, wd_r, o_rdata, o_err, o_lat, o_en, o_we, o_maddr);
      ref_access(we_r, f3_r, addr_r, wd_r, m_rdata, m_err, m_lat, m_mem);
      chk($sformatf("rnd%0d_rdata a=%h f3=%0d we=%0d", t, addr_r, f3_r, we_r), o_rdata, m_rdata);
      chk($sformatf("rnd%0d_err", t), 32'(o_err), 32'(m_err));
      chk($sformatf("rnd%0d_lat", t), 32'(o_lat), 32'(m_lat));
      chk($sformatf("rnd%0d_mem_en", t), 32'(o_en), 32'(m_mem));
    end
    for (int i = 0; i < NG; i++) chk($sformatf("final_gpo%0d", i), gpo[32*i +: 32], ref_gpo[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
